fil_dispatch_seq: RTL
=====================

FIL_DISPATCH_SEQ -- requirements
Module: fil_dispatch_seq

Interface
REQ-001 SHALL have parameter MNO, default 288, max filters/volumes per layer; counter width CW = $clog2(MNO)+1.
REQ-002 SHALL have parameter MAX_OUT, default 4, max filter commands issued but not yet answered by the DP.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle layer start pulse; sampled only in IDLE.
REQ-006 SHALL have port num_fil  input  CW  filter count for the layer (legal range 1..MNO); sampled on accepted start.
REQ-007 SHALL have port abort  input  1  synchronous layer cancel.
REQ-008 SHALL have port fil_valid  output  1  filter command valid to DP.
REQ-009 SHALL have port fil_ready  input  1  DP accepts command.
REQ-010 SHALL have port fil_idx  output  CW  filter index of current command.
REQ-011 SHALL have port res_valid  input  1  DP result strobe (same signal as valid_ac3 to done counter), one per command.
REQ-012 SHALL have port cnt_clear  output  1  clear strobe to done counter.
REQ-013 SHALL have port cnt_load  output  1  load strobe to done counter.
REQ-014 SHALL have port cnt_max  output  CW  max value for done counter; equals latched num_fil.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port layer_done  output  1  one-cycle pulse, all results returned.
REQ-017 SHALL have port err  output  1  one-cycle protocol error pulse.

Function
REQ-018 SHALL implement FSM states IDLE, CLR, LOAD, ISSUE, DRAIN, DONE.
REQ-019 SHALL go IDLE->CLR on start with num_fil in 1..MNO, latching num_fil; num_fil==0 or >MNO SHALL pulse err and stay IDLE.
REQ-020 SHALL assert cnt_clear only in CLR and cnt_load only in LOAD; never both in one cycle (clear has priority in the counter).
REQ-021 SHALL go CLR->LOAD->ISSUE unconditionally; first fil_valid earliest 3 cycles after start.
REQ-022 In ISSUE, SHALL assert fil_valid when issued<num_fil and outstanding<MAX_OUT.
REQ-023 Transfer occurs when fil_valid&&fil_ready; fil_idx starts at 0 and increments by 1 per transfer.
REQ-024 Once asserted, fil_valid and fil_idx SHALL hold stable until transfer, except on abort.
REQ-025 SHALL count outstanding as +1 per transfer, -1 per res_valid; simultaneous transfer and res_valid leave it unchanged.
REQ-026 SHALL go ISSUE->DRAIN in the cycle after the transfer with fil_idx==num_fil-1.
REQ-027 SHALL accept res_valid in ISSUE and DRAIN; returned counter increments per res_valid.
REQ-028 SHALL go DRAIN->DONE when returned reaches num_fil; layer_done SHALL be high the cycle after the final res_valid.
REQ-029 SHALL go DONE->IDLE after one cycle.
REQ-030 res_valid with outstanding==0 SHALL pulse err and be ignored.
REQ-031 start outside IDLE SHALL be ignored, with no err.
REQ-032 abort in any non-IDLE state SHALL force IDLE next cycle, zero counters, drop fil_valid, and pulse cnt_clear; no layer_done.
REQ-033 If abort and start coincide in IDLE, abort SHALL win.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 SHALL on rst_n low asynchronously enter IDLE; all outputs 0; fil_idx, issued, returned, outstanding, cnt_max = 0.

Structure
REQ-036 SHALL place MNO default, MAX_OUT default and the state enum in shared package dp_ctrl_pkg.
REQ-037 SHALL instantiate one sub-module fil_credit_cnt: up/down outstanding counter with full (==MAX_OUT) and empty flags.

Verification
REQ-038 Reset: assert rst_n=0 mid-ISSUE -> all outputs 0 immediately, IDLE after release.
REQ-039 num_fil=5, fil_ready=1, DP echoes res_valid 2 cycles after each transfer -> idx 0..4, cnt_clear@t1, cnt_load@t2 with cnt_max=5, exactly one layer_done.
REQ-040 num_fil=8, MAX_OUT=4, res_valid withheld -> exactly 4 transfers, fil_valid low; one res_valid -> fifth transfer follows.
REQ-041 fil_ready held low 10 cycles with fil_valid high -> fil_idx stable; same-cycle transfer+res_valid -> outstanding unchanged.
REQ-042 start with num_fil=0; res_valid in IDLE; start during DRAIN -> err pulse, err pulse, ignored respectively.
REQ-043 abort in DRAIN with 2 outstanding -> IDLE next cycle, cnt_clear pulse, no layer_done; new start with num_fil=1 completes normally.

Source files
------------

// File: rtl/dp_ctrl_pkg.sv
// Shared constants and FSM state encoding for the datapath control blocks.
package dp_ctrl_pkg;

  localparam int MNO_DEF     = 288;
  localparam int MAX_OUT_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/fil_dispatch_seq_if.sv
// Filter command / result handshake between the dispatcher and the datapath.
interface fil_dispatch_seq_if
  import dp_ctrl_pkg::*;
#(
  parameter int CW = $clog2(MNO_DEF) + 1
) ();

  logic          fil_valid;
  logic          fil_ready;
  logic [CW-1:0] fil_idx;
  logic          res_valid;

  modport master (output fil_valid, fil_idx, input fil_ready, res_valid);
  modport slave  (input fil_valid, fil_idx, output fil_ready, res_valid);

endinterface

// File: rtl/fil_credit_cnt.sv
// Up/down count of filter commands issued but not yet answered by the datapath.
module fil_credit_cnt #(
  parameter int  MAX_OUT = 4,
  localparam int OW      = $clog2(MAX_OUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  logic [OW-1:0] cnt_q, cnt_d;

  // NOTE: default assignment first so every path assigns cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)               cnt_d = '0;
    else if (inc_i && !dec_i) cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i) cnt_d = cnt_q - 1'b1;
  end

  // full reflects the count being loaded this cycle, so a registered valid can drop in time.
  assign full_o  = (cnt_d == OW'(MAX_OUT));
  assign empty_o = (cnt_q == '0);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fil_dispatch_seq.sv
// Layer sequencer: clears/loads the done counter, then issues filter commands under a credit limit.
module fil_dispatch_seq
  import dp_ctrl_pkg::*;
#(
  parameter int  MNO     = MNO_DEF,
  parameter int  MAX_OUT = MAX_OUT_DEF,
  localparam int CW      = $clog2(MNO) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CW-1:0]      num_fil,
  input  logic               abort,
  output logic               cnt_clear,
  output logic               cnt_load,
  output logic [CW-1:0]      cnt_max,
  output logic               busy,
  output logic               layer_done,
  output logic               err,
  fil_dispatch_seq_if.master dp
);

  state_e        state_q;
  logic [CW-1:0] num_q, issued_q, returned_q;
  logic          fil_valid_q, cnt_clear_q, cnt_load_q, busy_q, layer_done_q, err_q;
  logic          xfer, res_ok, res_bad, credit_clr, full, empty, num_legal;

  assign xfer       = fil_valid_q && dp.fil_ready;
  assign res_ok     = dp.res_valid && !empty;
  assign res_bad    = dp.res_valid && empty;
  assign credit_clr = abort && (state_q != IDLE);
  assign num_legal  = (num_fil != '0) && (num_fil <= CW'(MNO));

  fil_credit_cnt #(.MAX_OUT(MAX_OUT)) u_credit (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (credit_clr),
    .inc_i   (xfer),
    .dec_i   (res_ok),
    .full_o  (full),
    .empty_o (empty)
  );

  // NOTE: only control registers are reset here; no memories are involved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      num_q        <= '0;
      issued_q     <= '0;
      returned_q   <= '0;
      fil_valid_q  <= 1'b0;
      cnt_clear_q  <= 1'b0;
      cnt_load_q   <= 1'b0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cnt_clear_q  <= 1'b0;
      cnt_load_q   <= 1'b0;
      layer_done_q <= 1'b0;
      err_q        <= res_bad;
      if (credit_clr) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        fil_valid_q <= 1'b0;
        cnt_clear_q <= 1'b1;
        issued_q    <= '0;
        returned_q  <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start && !abort) begin
              if (num_legal) begin
                state_q     <= CLR;
                busy_q      <= 1'b1;
                num_q       <= num_fil;
                issued_q    <= '0;
                returned_q  <= '0;
                cnt_clear_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          CLR: begin
            state_q    <= LOAD;
            cnt_load_q <= 1'b1;
          end
          LOAD: begin
            state_q     <= ISSUE;
            fil_valid_q <= 1'b1;
          end
          ISSUE: begin
            if (res_ok) returned_q <= returned_q + 1'b1;
            if (xfer) issued_q <= issued_q + 1'b1;
            // Valid never drops without a transfer: the credit count can only fall while waiting.
            if (xfer && (issued_q == num_q - 1'b1)) begin
              state_q     <= DRAIN;
              fil_valid_q <= 1'b0;
            end else begin
              fil_valid_q <= !full;
            end
          end
          DRAIN: begin
            if (res_ok) begin
              returned_q <= returned_q + 1'b1;
              if (returned_q == num_q - 1'b1) begin
                state_q      <= DONE;
                layer_done_q <= 1'b1;
              end
            end
          end
          DONE: begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            issued_q   <= '0;
            returned_q <= '0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dp.fil_valid = fil_valid_q;
  assign dp.fil_idx   = issued_q;
  assign cnt_clear    = cnt_clear_q;
  assign cnt_load     = cnt_load_q;
  assign cnt_max      = num_q;
  assign busy         = busy_q;
  assign layer_done   = layer_done_q;
  assign err          = err_q;

endmodule
